// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector (KMP fallback), registered match pulse.
// Optional saturating match counter with clr_cnt, enabled by macro SEQ_DETECT_CNT_EN.
module seq_detect_param #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int KW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  // Next-state table indexed by {k, bit}: longest pattern prefix (shorter than PAT_W)
  // that is a suffix of prefix_k followed by bit. Covers both advance and fallback.
  function automatic logic [2*PAT_W*KW-1:0] build_next();
    logic [2*PAT_W*KW-1:0] tbl;
    int   best;
    int   j;
    logic ok;
    logic sbit;
    tbl = '0;
    for (int k = 0; k < PAT_W; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int l = 1; l <= k + 1; l++) begin
          if (l < PAT_W) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
              j    = k + 1 - l + i;
              sbit = (j < k) ? PATTERN[PAT_W-1-j] : (b != 0);
              if (PATTERN[PAT_W-1-i] != sbit) ok = 1'b0;
            end
            if (ok) best = l;
          end
        end
        tbl[(2*k+b)*KW +: KW] = best[KW-1:0];
      end
    end
    return tbl;
  endfunction

  function automatic logic [KW-1:0] build_lps();
    int   best;
    logic ok;
    best = 0;
    for (int l = 1; l < PAT_W; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (PATTERN[PAT_W-1-i] != PATTERN[l-1-i]) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best[KW-1:0];
  endfunction

  localparam logic [2*PAT_W*KW-1:0] NEXT_TBL = build_next();
  localparam logic [KW-1:0]         LPS      = build_lps();
  localparam logic [KW-1:0]         K_LAST   = KW'(PAT_W - 1);

  logic [KW-1:0]    k_q, k_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_comb begin
    hit   = en && (k_q == K_LAST) && (in == PATTERN[0]);
    out_d = hit;
    k_d   = k_q;
    if (hit) begin
      k_d = overlap ? LPS : '0;
    end else if (en) begin
      k_d = NEXT_TBL[(2*int'(k_q) + int'(in))*KW +: KW];
    end
`ifdef SEQ_DETECT_CNT_EN
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
`else
    cnt_d = '0;
`endif
  end

`ifndef SEQ_DETECT_CNT_EN
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      k_q   <= k_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed bench for seq_detect_param (CNT_W=8 and CNT_W=2 instances).
// Expected counts follow SEQ_DETECT_CNT_EN: zero when the macro is undefined.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n, en, in_b, overlap, clr_cnt;
  logic       out8, out2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int         checks = 0;
  int         errors = 0;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam logic [3:0] PAT = 4'b1011;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in_b), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(out8), .match_cnt(cnt8)
  );

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in_b), .overlap(overlap),
    .clr_cnt(clr_cnt), .out(out2), .match_cnt(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: window of the last 4 accepted bits plus how many of them are eligible
  logic [3:0] win = '0;
  int         nvalid = 0;
  logic       exp_out = 1'b0;
  int         exp_c8 = 0;
  int         exp_c2 = 0;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin : model
    logic hit;
    hit = 1'b0;
    if (!rst_n) begin
      nvalid  = 0;
      exp_out = 1'b0;
      exp_c8  = 0;
      exp_c2  = 0;
    end else begin
      if (en) begin
        win = {win[2:0], in_b};
        if (nvalid < 4) nvalid++;
        if (nvalid == 4 && win == PAT) begin
          hit = 1'b1;
          if (!overlap) nvalid = 0;
        end
      end
      exp_out = hit;
      if (CNT_ON) begin
        if (clr_cnt) begin
          exp_c8 = 0;
          exp_c2 = 0;
        end else if (hit) begin
          if (exp_c8 < 255) exp_c8++;
          if (exp_c2 < 3)   exp_c2++;
        end
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmp_out8", out8, exp_out);
      chk("cmp_out2", out2, exp_out);
      chk("cmp_cnt8", cnt8, exp_c8);
      chk("cmp_cnt2", cnt2, exp_c2);
    end
  end

  function automatic int lit(input int v);
    return CNT_ON ? v : 0;
  endfunction

  task automatic cyc(input logic e, input logic b);
    en   = e;
    in_b = b;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input string nm, input string bits, input string ens, input string outs);
    for (int i = 0; i < bits.len(); i++) begin
      cyc(ens[i] == "1", bits[i] == "1");
      chk({nm, "_out"}, out8, outs[i] == "1");
      chk({nm, "_model"}, exp_out, outs[i] == "1");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_b = 1'b0; overlap = 1'b0; clr_cnt = 1'b0;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("reset_out", out8, 0);
    chk("reset_cnt8", cnt8, 0);
    chk("reset_cnt2", cnt2, 0);
    chk("reset_k", dut8.k_q, 0);
    rst_n = 1'b1;

    overlap = 1'b1;
    run("ovl", "1011011", "1111111", "0001001");
    chk("ovl_cnt", cnt8, lit(2));

    do_reset();
    overlap = 1'b0;
    run("novl", "1011011", "1111111", "0001000");
    chk("novl_cnt", cnt8, lit(1));

    do_reset();
    overlap = 1'b1;
    run("gap", "1011111", "1100011", "0000001");
    chk("gap_cnt", cnt8, lit(1));

    do_reset();
    run("rst", "101", "111", "000");
    rst_n = 1'b0;
    cyc(1'b1, 1'b1);
    chk("rst_out", out8, 0);
    chk("rst_k", dut8.k_q, 0);
    chk("rst_cnt", cnt8, 0);
    rst_n = 1'b1;
    run("rst2", "1011", "1111", "0001");

    do_reset();
    overlap = 1'b1;
    run("kmp", "11011001011", "11111111111", "00001000001");
    chk("kmp_cnt", cnt8, lit(2));

    do_reset();
    overlap = 1'b1;
    run("om1", "101", "111", "000");
    overlap = 1'b0;
    run("om2", "1011", "1111", "1000");

    do_reset();
    overlap = 1'b1;
    run("sat", "1011011011011011", "1111111111111111", "0001001001001001");
    chk("sat_cnt2", cnt2, lit(3));
    chk("sat_cnt8", cnt8, lit(5));
    run("sat6", "01", "11", "00");
    clr_cnt = 1'b1;
    cyc(1'b1, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_out", out8, 1);
    chk("clr_cnt2", cnt2, 0);
    chk("clr_cnt8", cnt8, 0);
    cyc(1'b0, 1'b0);
    chk("clr_after", out8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
